// File: rtl/tetris_vga_pkg.sv
// Shared raster timing constants, the decoded timing bundle type and small
// helpers used by the VGA timing generator and its axis counters.
package tetris_vga_pkg;

  localparam int unsigned VGA_PIX_WIDTH = 12;

  localparam int unsigned VGA_640x480_H_DISP   = 640;
  localparam int unsigned VGA_640x480_H_FPORCH = 16;
  localparam int unsigned VGA_640x480_H_SYNC   = 96;
  localparam int unsigned VGA_640x480_H_BPORCH = 48;
  localparam int unsigned VGA_640x480_V_DISP   = 480;
  localparam int unsigned VGA_640x480_V_FPORCH = 10;
  localparam int unsigned VGA_640x480_V_SYNC   = 2;
  localparam int unsigned VGA_640x480_V_BPORCH = 33;

  localparam int unsigned VGA_1280x1024_H_DISP   = 1280;
  localparam int unsigned VGA_1280x1024_H_FPORCH = 48;
  localparam int unsigned VGA_1280x1024_H_SYNC   = 112;
  localparam int unsigned VGA_1280x1024_H_BPORCH = 248;
  localparam int unsigned VGA_1280x1024_V_DISP   = 1024;
  localparam int unsigned VGA_1280x1024_V_FPORCH = 1;
  localparam int unsigned VGA_1280x1024_V_SYNC   = 3;
  localparam int unsigned VGA_1280x1024_V_BPORCH = 38;

  typedef struct packed {
    logic                     hs;
    logic                     vs;
    logic                     de;
    logic [VGA_PIX_WIDTH-1:0] x;
    logic [VGA_PIX_WIDTH-1:0] y;
  } vga_timing_t;

  function automatic logic sync_level(input logic active, input logic act_high);
    return act_high ? active : ~active;
  endfunction

  function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                   input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/tetris_vga_timing_if.sv
// Bundle of the registered raster timing outputs; master drives, slave consumes.
interface tetris_vga_timing_if #(
  parameter int unsigned PIX_WIDTH = 12
);
  logic                 hs;
  logic                 vs;
  logic                 de;
  logic [PIX_WIDTH-1:0] x;
  logic [PIX_WIDTH-1:0] y;
  logic                 frame_start;
  logic                 vblank_start;
  logic [15:0]          frame_cnt;

  modport master (
    output hs, vs, de, x, y, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    input hs, vs, de, x, y, frame_start, vblank_start, frame_cnt
  );
endinterface

// File: rtl/tetris_vga_axis_cnt.sv
// One raster axis: counts 0..TOT-1 when inc_i is high and decodes the display
// and sync regions (order: display, front porch, sync, back porch).
module tetris_vga_axis_cnt
  import tetris_vga_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = 12,
  parameter int unsigned DISP      = 1280,
  parameter int unsigned FPORCH    = 48,
  parameter int unsigned SYNC      = 112,
  parameter int unsigned BPORCH    = 248
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  output logic [PIX_WIDTH-1:0] cnt_o,
  output logic                 wrap_o,
  output logic                 disp_o,
  output logic                 sync_o
);

  localparam int unsigned          TOT  = DISP + FPORCH + SYNC + BPORCH;
  localparam logic [PIX_WIDTH-1:0] LAST = PIX_WIDTH'(TOT - 1);

  if (DISP == 0 || FPORCH == 0 || SYNC == 0 || BPORCH == 0) begin : g_bad_zero
    $error("tetris_vga_axis_cnt: timing parameters must be non-zero");
  end
  if (64'(TOT) > (64'd1 << PIX_WIDTH)) begin : g_bad_width
    $error("tetris_vga_axis_cnt: total period does not fit in PIX_WIDTH");
  end

  logic [PIX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap_o  = inc_i && at_last;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    disp_o = in_span(32'(cnt_q), 0, DISP);
    sync_o = in_span(32'(cnt_q), DISP + FPORCH, SYNC);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tetris_vga_timing.sv
// Free-running raster timing generator: registered hsync/vsync/de, pixel
// coordinates, frame/vblank strobes and a frame counter, all mutually aligned.
module tetris_vga_timing
  import tetris_vga_pkg::*;
#(
  parameter int unsigned PIX_WIDTH      = 12,
  parameter int unsigned H_DISP         = 1280,
  parameter int unsigned H_FPORCH       = 48,
  parameter int unsigned H_SYNC         = 112,
  parameter int unsigned H_BPORCH       = 248,
  parameter int unsigned V_DISP         = 1024,
  parameter int unsigned V_FPORCH       = 1,
  parameter int unsigned V_SYNC         = 3,
  parameter int unsigned V_BPORCH       = 38,
  parameter bit          HS_ACT_HIGH    = 1'b0,
  parameter bit          VS_ACT_HIGH    = 1'b0,
  parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
  input  logic                 clk_vga_i,
  input  logic                 rst_i,
  output logic                 pix_hs_o,
  output logic                 pix_vs_o,
  output logic                 pix_de_o,
  output logic [PIX_WIDTH-1:0] pix_x_o,
  output logic [PIX_WIDTH-1:0] pix_y_o,
  output logic                 frame_start_o,
  output logic                 vblank_start_o,
  output logic [15:0]          frame_cnt_o
);

  localparam logic                 HS_IDLE = ~HS_ACT_HIGH;
  localparam logic                 VS_IDLE = ~VS_ACT_HIGH;
  localparam logic [PIX_WIDTH-1:0] V_DISP_W = PIX_WIDTH'(V_DISP);

  logic [PIX_WIDTH-1:0] h_cnt, v_cnt;
  logic                 h_wrap, h_disp, h_sync;
  logic                 v_wrap, v_disp, v_sync;

  tetris_vga_axis_cnt #(
    .PIX_WIDTH (PIX_WIDTH),
    .DISP      (H_DISP),
    .FPORCH    (H_FPORCH),
    .SYNC      (H_SYNC),
    .BPORCH    (H_BPORCH)
  ) u_h_cnt (
    .clk_i  (clk_vga_i),
    .rst_i  (rst_i),
    .inc_i  (1'b1),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap),
    .disp_o (h_disp),
    .sync_o (h_sync)
  );

  tetris_vga_axis_cnt #(
    .PIX_WIDTH (PIX_WIDTH),
    .DISP      (V_DISP),
    .FPORCH    (V_FPORCH),
    .SYNC      (V_SYNC),
    .BPORCH    (V_BPORCH)
  ) u_v_cnt (
    .clk_i  (clk_vga_i),
    .rst_i  (rst_i),
    .inc_i  (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap),
    .disp_o (v_disp),
    .sync_o (v_sync)
  );

  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 de_q, de_d;
  logic [PIX_WIDTH-1:0] x_q, x_d;
  logic [PIX_WIDTH-1:0] y_q, y_d;
  logic                 fs_q, fs_d;
  logic                 vb_q, vb_d;
  logic [15:0]          fc_q, fc_d;

  // v_wrap already implies h_wrap, since the V counter only advances on H wrap
  always_comb begin
    hs_d = sync_level(h_sync, HS_ACT_HIGH);
    vs_d = sync_level(v_sync, VS_ACT_HIGH);
    de_d = h_disp && v_disp;
    x_d  = de_d ? h_cnt : '0;
    y_d  = de_d ? v_cnt : '0;
    fs_d = (h_cnt == '0) && (v_cnt == '0);
    vb_d = (h_cnt == '0) && (v_cnt == V_DISP_W);
    fc_d = fc_q + {15'd0, v_wrap};
  end

  always_ff @(posedge clk_vga_i or posedge rst_i) begin
    if (rst_i) begin
      hs_q <= HS_IDLE;
      vs_q <= VS_IDLE;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
      vb_q <= 1'b0;
      fc_q <= FRAME_CNT_INIT;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      x_q  <= x_d;
      y_q  <= y_d;
      fs_q <= fs_d;
      vb_q <= vb_d;
      fc_q <= fc_d;
    end
  end

  assign pix_hs_o       = hs_q;
  assign pix_vs_o       = vs_q;
  assign pix_de_o       = de_q;
  assign pix_x_o        = x_q;
  assign pix_y_o        = y_q;
  assign frame_start_o  = fs_q;
  assign vblank_start_o = vb_q;
  assign frame_cnt_o    = fc_q;

endmodule
